div64_res_packer: RTL

//  Downstream stage of the 64-bit divider: captures each quotient/remainder/err result,

---
 rtl/div64_res_packer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/div64_res_packer.sv
// div64_res_packer: buffers divider results in a small FIFO and streams each one
// as an 18-byte frame over a byte valid/ready interface.
//   clk, rst       : clock and asynchronous active-high reset
//   in_valid       : one-cycle strobe qualifying quot/rem/err_in
//   quot, rem      : 64-bit quotient and remainder
//   err_in         : divide-by-zero flag for the result
//   byte_out       : frame byte; byte_valid/byte_ready handshake
//   frame_start    : high with header byte, frame_end high with checksum byte
//   ovf_flag       : sticky drop indicator, cleared by ovf_clr
//   fifo_level     : number of buffered results (0..DEPTH)
// Frame: {1,err,00,seq[3:0]}, quotient MSB first, remainder MSB first, XOR of bytes 0..16.
module div64_res_packer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [63:0]   quot,
    input  logic [63:0]   rem,
    input  logic          err_in,
    output logic [7:0]    byte_out,
    output logic          byte_valid,
    input  logic          byte_ready,
    output logic          frame_start,
    output logic          frame_end,
    output logic          ovf_flag,
    input  logic          ovf_clr,
    output logic [AW:0]   fifo_level
);

    typedef struct packed {
        logic [3:0]  seq;
        logic        err;
        logic [63:0] quot;
        logic [63:0] rem;
    } entry_t;

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [4:0]  LAST_K   = 5'd17;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [3:0]    seq;
    state_t        state;
    entry_t        frame;
    logic [4:0]    k;
    logic [7:0]    chk;

    logic pop;
    logic push;
    logic drop;

    // Byte k of the frame for entry e; chk_acc is the XOR of bytes 0..16 when k is the last index.
    function automatic logic [7:0] frame_byte(input entry_t e, input logic [4:0] kk,
                                              input logic [7:0] chk_acc);
        logic [127:0] payload;
        logic [3:0]   ridx;
        logic [7:0]   b;
        payload = {e.quot, e.rem};
        ridx    = 4'(5'd16 - kk);
        b       = 8'h00;
        if (kk == 5'd0)
            b = {1'b1, e.err, 2'b00, e.seq};
        else if (kk == LAST_K)
            b = chk_acc;
        else if (!e.err)
            b = payload[{ridx, 3'b000} +: 8];
        return b;
    endfunction

    // A pop in the same cycle frees the slot, so a push while full still lands.
    always_comb begin
        pop  = (state == IDLE) && (level != '0);
        push = in_valid && ((level != FULL_LVL) || pop);
        drop = in_valid && !push;
    end

    // Result storage; no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{seq: seq, err: err_in, quot: quot, rem: rem};
    end

    // FIFO pointers, level, sequence counter and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            seq      <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                seq    <= seq + 4'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (drop)
                ovf_flag <= 1'b1;
            else if (ovf_clr)
                ovf_flag <= 1'b0;
        end
    end

    assign fifo_level = level;

    // Frame sender: byte_out always holds byte k, advancing only on an accepted handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            frame       <= '0;
            k           <= '0;
            chk         <= '0;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        frame       <= mem[rd_ptr];
                        k           <= '0;
                        chk         <= '0;
                        byte_out    <= frame_byte(mem[rd_ptr], 5'd0, 8'h00);
                        byte_valid  <= 1'b1;
                        frame_start <= 1'b1;
                        frame_end   <= 1'b0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (byte_ready) begin
                        chk <= chk ^ byte_out;
                        if (k == LAST_K) begin
                            byte_out    <= '0;
                            byte_valid  <= 1'b0;
                            frame_start <= 1'b0;
                            frame_end   <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            k           <= k + 5'd1;
                            byte_out    <= frame_byte(frame, k + 5'd1, chk ^ byte_out);
                            frame_start <= 1'b0;
                            frame_end   <= ((k + 5'd1) == LAST_K);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
